// File: rtl/idct_pkg.sv
// Shared types and constants for the IDCT transpose stage.
package idct_pkg;

  localparam int W = 16;

  // Block lengths in samples
  localparam int N4 = 16;
  localparam int N8 = 64;

  localparam logic MODE_4X4 = 1'b0;
  localparam logic MODE_8X8 = 1'b1;

  // Ring address width (128-word sample ring)
  localparam int RING_AW = 7;

  // Pending-block descriptor: where the block starts in the ring and its size
  typedef struct packed {
    logic [RING_AW-1:0] base;
    logic               mode;
  } desc_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_BUSY = 1'b1
  } rd_state_t;

  // Offset of output k inside a block: (k mod n)*n + (k div n).
  // With n a power of two this is a swap of the low and high index fields.
  function automatic logic [5:0] transpose_offset(input logic [5:0] k, input logic md);
    if (md == MODE_8X8) begin
      return {k[2:0], k[5:3]};
    end
    return {2'b00, k[1:0], k[3:2]};
  endfunction

  // Index of the final sample of a block
  function automatic logic [5:0] last_index(input logic md);
    return (md == MODE_8X8) ? 6'(N8 - 1) : 6'(N4 - 1);
  endfunction

endpackage

// File: rtl/blk_desc_fifo.sv
// Small show-ahead FIFO holding descriptors of complete, not-yet-read blocks.
module blk_desc_fifo
  import idct_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  desc_t din,
  input  logic  pop,
  output logic  empty,
  output desc_t dout
);

  localparam int PW = $clog2(DEPTH);

  desc_t          r_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [PW:0]    r_count;

  logic           w_full;
  logic           w_do_push;
  logic           w_do_pop;

  assign empty     = (r_count == '0);
  assign w_full    = (r_count == (PW + 1)'(DEPTH));
  assign w_do_push = push && !w_full;
  assign w_do_pop  = pop && !empty;
  assign dout      = r_mem[r_rd_ptr];

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Descriptor storage
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/transpose_mem.sv
// Transpose buffer: collects 4x4/8x8 blocks in a sample ring and streams each
// complete block back out column-by-column with its mode.
module transpose_mem #(
  parameter int W          = idct_pkg::W,
  parameter int RING_DEPTH = 128,
  parameter int DESC_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] data_write,
  input  logic         enable,
  input  logic         mode,
  output logic [W-1:0] data_read,
  output logic         outmode,
  output logic         readenable
);

  import idct_pkg::*;

  localparam int AW = RING_AW;

  logic [W-1:0]  r_ring [RING_DEPTH];

  // Write side
  logic [5:0]    r_wi;
  logic [AW-1:0] r_base;
  logic          r_wmode;
  logic          w_blk_mode;
  logic          w_blk_last;
  logic [AW-1:0] w_waddr;
  desc_t         w_push_desc;

  // Descriptor FIFO
  logic          w_fifo_empty;
  logic          w_pop;
  desc_t         w_fifo_dout;

  // Read side
  rd_state_t     r_state, w_state_next;
  logic [5:0]    r_k, w_k_next;
  logic [AW-1:0] r_rbase, w_rbase_next;
  logic          r_rmode, w_rmode_next;
  logic          w_rd_en;
  logic [5:0]    w_cur_k;
  logic [AW-1:0] w_cur_base;
  logic          w_cur_mode;
  logic [AW-1:0] w_raddr;

  // Mode is taken from the port only on the first sample of a block
  assign w_blk_mode  = (r_wi == 6'd0) ? mode : r_wmode;
  assign w_blk_last  = enable && (r_wi == last_index(w_blk_mode));
  assign w_waddr     = r_base + AW'(r_wi);
  assign w_push_desc = '{base: r_base, mode: w_blk_mode};

  // Write index, block base and captured block mode
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wi    <= '0;
      r_base  <= '0;
      r_wmode <= MODE_4X4;
    end else if (enable) begin
      if (r_wi == 6'd0) r_wmode <= mode;
      if (w_blk_last) begin
        r_wi   <= '0;
        r_base <= r_base + ((w_blk_mode == MODE_8X8) ? AW'(N8) : AW'(N4));
      end else begin
        r_wi <= r_wi + 1'b1;
      end
    end
  end

  // Sample ring write port; contents survive reset
  always_ff @(posedge clk) begin
    if (enable) r_ring[w_waddr] <= data_write;
  end

  blk_desc_fifo #(
    .DEPTH (DESC_DEPTH)
  ) u_desc_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_blk_last),
    .din   (w_push_desc),
    .pop   (w_pop),
    .empty (w_fifo_empty),
    .dout  (w_fifo_dout)
  );

  // Reader state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RD_IDLE;
      r_k     <= '0;
      r_rbase <= '0;
      r_rmode <= MODE_4X4;
    end else begin
      r_state <= w_state_next;
      r_k     <= w_k_next;
      r_rbase <= w_rbase_next;
      r_rmode <= w_rmode_next;
    end
  end

  // Reader next-state and read address selection; an idle reader emits
  // element 0 of a fresh descriptor on the same edge it pops it
  always_comb begin
    w_state_next = r_state;
    w_k_next     = r_k;
    w_rbase_next = r_rbase;
    w_rmode_next = r_rmode;
    w_pop        = 1'b0;
    w_rd_en      = 1'b0;
    w_cur_k      = r_k;
    w_cur_base   = r_rbase;
    w_cur_mode   = r_rmode;
    case (r_state)
      RD_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_rd_en      = 1'b1;
          w_cur_k      = '0;
          w_cur_base   = w_fifo_dout.base;
          w_cur_mode   = w_fifo_dout.mode;
          w_state_next = RD_BUSY;
          w_k_next     = 6'd1;
          w_rbase_next = w_fifo_dout.base;
          w_rmode_next = w_fifo_dout.mode;
        end
      end
      RD_BUSY: begin
        w_rd_en = 1'b1;
        if (r_k == last_index(r_rmode)) begin
          w_k_next = '0;
          if (!w_fifo_empty) begin
            w_pop        = 1'b1;
            w_rbase_next = w_fifo_dout.base;
            w_rmode_next = w_fifo_dout.mode;
          end else begin
            w_state_next = RD_IDLE;
          end
        end else begin
          w_k_next = r_k + 1'b1;
        end
      end
      default: w_state_next = RD_IDLE;
    endcase
  end

  assign w_raddr = w_cur_base + AW'(transpose_offset(w_cur_k, w_cur_mode));

  // Registered ring read and output flags
  always_ff @(posedge clk) begin
    if (reset) begin
      data_read  <= '0;
      readenable <= 1'b0;
      outmode    <= MODE_4X4;
    end else begin
      readenable <= w_rd_en;
      if (w_rd_en) begin
        data_read <= r_ring[w_raddr];
        outmode   <= w_cur_mode;
      end else begin
        data_read <= '0;
      end
    end
  end

endmodule

// File: tb/tb_transpose_mem.sv
// Directed + random bench for transpose_mem with a block-level reference model.
module tb_transpose_mem;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] data_write = '0;
  logic [W-1:0] data_read;
  logic         outmode;
  logic         readenable;

  transpose_mem #(
    .W          (W),
    .RING_DEPTH (128),
    .DESC_DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_write (data_write),
    .enable     (enable),
    .mode       (mode),
    .data_read  (data_read),
    .outmode    (outmode),
    .readenable (readenable)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Expected output sample: the edge after which it must be visible
  typedef struct {
    int           at;
    logic [W-1:0] val;
    logic         md;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] cur_blk[$];
  logic         cur_mode = 1'b0;
  int           rd_free = 0;
  logic         last_mode = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  // One clock: drive inputs, advance the model, compare outputs after the edge
  task automatic step(input logic en, input logic [W-1:0] d, input logic md, input logic rst);
    int   n;
    int   start;
    exp_t e;
    @(negedge clk);
    enable = en;
    data_write = d;
    mode = md;
    reset = rst;
    @(posedge clk);
    cyc++;
    if (rst) begin
      cur_blk.delete();
      exp_q.delete();
      rd_free = 0;
      last_mode = 1'b0;
    end else if (en) begin
      if (cur_blk.size() == 0) cur_mode = md;
      cur_blk.push_back(d);
      n = cur_mode ? 8 : 4;
      if (cur_blk.size() == n * n) begin
        // A finished block is readable from the next edge, or once the previous block has drained
        start = (cyc + 1 > rd_free) ? cyc + 1 : rd_free;
        for (int k = 0; k < n * n; k++) begin
          exp_q.push_back('{start + k, cur_blk[(k % n) * n + k / n], cur_mode});
        end
        rd_free = start + n * n;
        $display("block complete cyc=%0d mode=%0d first_out_cyc=%0d", cyc, cur_mode, start);
        cur_blk.delete();
      end
    end
    #1;
    if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
      e = exp_q.pop_front();
      check("readenable_busy", readenable, 1);
      check("data_read", data_read, e.val);
      check("outmode_busy", outmode, e.md);
      last_mode = e.md;
    end else begin
      check("readenable_idle", readenable, 0);
      check("data_read_idle", data_read, 0);
      check("outmode_hold", outmode, last_mode);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic write_block(input logic md, input int first);
    int n;
    n = md ? 64 : 16;
    for (int i = 0; i < n; i++) step(1'b1, W'(first + i), md, 1'b0);
  endtask

  // Run idle cycles until every expected sample has been seen, bounded
  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 300) begin
      step(1'b0, '0, 1'b0, 1'b0);
      guard++;
    end
    check("drain_complete", exp_q.size(), 0);
    idle(2);
  endtask

  initial begin
    // Reset state
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    idle(2);

    // Single 4x4 block, values 0..15
    write_block(1'b0, 0);
    drain();

    // Single 8x8 block, values 0..63
    write_block(1'b1, 0);
    drain();

    // Continuous mixed stream: 8x8, four 4x4, 8x8
    write_block(1'b1, 0);
    for (int b = 0; b < 4; b++) write_block(1'b0, 100 + 16 * b);
    write_block(1'b1, 200);
    drain();

    // 4x4 with a 5-cycle enable gap after sample 7
    for (int i = 0; i < 16; i++) begin
      step(1'b1, W'(i), 1'b0, 1'b0);
      if (i == 7) idle(5);
    end
    drain();

    // Mode changes to 1 after sample 3; block must remain 4x4
    for (int i = 0; i < 16; i++) step(1'b1, W'(50 + i), (i > 3), 1'b0);
    drain();

    // Reset after 10 samples, then a fresh 4x4 block
    for (int i = 0; i < 10; i++) step(1'b1, W'(300 + i), 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    write_block(1'b0, 400);
    drain();

    // Reset during readout, then a fresh 4x4 block
    write_block(1'b1, 500);
    idle(6);
    step(1'b0, '0, 1'b0, 1'b1);
    write_block(1'b0, 700);
    drain();

    // Random stream with gaps and mixed modes
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 3) != 0), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end
    // Finish any partial block so the model and the design end aligned
    while (cur_blk.size() != 0) step(1'b1, W'($urandom), 1'b0, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
